// File: rtl/first_stage_pkg.sv
// Shared constants and helpers for the hidden-layer (first_stage) and output-layer engines.
// Q8.8 fixed point throughout; accumulators are wide enough for 256 full-scale products.
package first_stage_pkg;

    localparam int Q_FRAC_BITS      = 8;
    localparam int ELEMENT_WIDTH    = 16;
    localparam int ACC_WIDTH        = 40;
    localparam int LANES            = 4;
    localparam int NEURONS_PER_LANE = 16;

    localparam logic [ELEMENT_WIDTH-1:0] Q88_MAX = 16'h7FFF;
    localparam logic [ELEMENT_WIDTH-1:0] Q88_MIN = 16'h8000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Drop the extra fraction bits of a Q16.16 sum, then clamp into 0..Q88_MAX (ReLU + saturate).
    function automatic logic [ELEMENT_WIDTH-1:0] relu_sat(input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH-1:0] r;
        r = acc >>> Q_FRAC_BITS;
        if (r > $signed({{(ACC_WIDTH-ELEMENT_WIDTH){1'b0}}, Q88_MAX}))
            return Q88_MAX;
        else if (r < 0)
            return '0;
        else
            return r[ELEMENT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/first_stage_mac.sv
// One neuron lane: signed multiply-accumulate into a wide accumulator, and a
// rescaled/saturated/ReLU output register loaded on emit.
module mac_lane
    import first_stage_pkg::*;
(
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     mac_en,
    input  logic                     emit,
    input  logic [ELEMENT_WIDTH-1:0] x,
    input  logic [ELEMENT_WIDTH-1:0] w,
    output logic [ELEMENT_WIDTH-1:0] z
);

    logic signed [ACC_WIDTH-1:0]       acc;
    logic signed [2*ELEMENT_WIDTH-1:0] prod;

    assign prod = $signed(x) * $signed(w);

    always_ff @(posedge clock) begin
        if (clear) begin
            acc <= '0;
            z   <= '0;
        end else if (start) begin
            acc <= '0;
        end else if (emit) begin
            z   <= relu_sat(acc);
            acc <= '0;
        end else if (mac_en) begin
            acc <= acc + {{(ACC_WIDTH-2*ELEMENT_WIDTH){prod[2*ELEMENT_WIDTH-1]}}, prod};
        end
    end

endmodule

// File: rtl/first_stage.sv
// Hidden-layer engine: walks 16 neuron steps of INPUT_LENGTH weight beats each,
// feeding four mac_lane instances and strobing their results to the second stage.
module first_stage
    import first_stage_pkg::*;
#(
    parameter int INPUT_LENGTH = 16,
    parameter int X_ADDR_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     en,
    output logic [X_ADDR_WIDTH-1:0]  x_ram_address,
    output logic                     x_ram_enable,
    input  logic [ELEMENT_WIDTH-1:0] x_ram_data,
    output logic                     w_element_requested,
    input  logic                     w_element_ready,
    input  logic [ELEMENT_WIDTH-1:0] w0_element,
    input  logic [ELEMENT_WIDTH-1:0] w1_element,
    input  logic [ELEMENT_WIDTH-1:0] w2_element,
    input  logic [ELEMENT_WIDTH-1:0] w3_element,
    output logic [ELEMENT_WIDTH-1:0] z0_element,
    output logic [ELEMENT_WIDTH-1:0] z1_element,
    output logic [ELEMENT_WIDTH-1:0] z2_element,
    output logic [ELEMENT_WIDTH-1:0] z3_element,
    output logic                     z0_element_ready,
    output logic                     z1_element_ready,
    output logic                     z2_element_ready,
    output logic                     z3_element_ready,
    output logic                     finished
);

    localparam logic [X_ADDR_WIDTH-1:0] I_LAST = X_ADDR_WIDTH'(INPUT_LENGTH - 1);
    localparam logic [3:0]              J_LAST = 4'(NEURONS_PER_LANE - 1);

    state_t                              state;
    logic [X_ADDR_WIDTH-1:0]             i;
    logic [3:0]                          j;
    logic [ELEMENT_WIDTH-1:0]            x_reg;
    logic                                first_wait;
    logic                                z_ready;

    logic                                start;
    logic                                mac_en;
    logic                                emit;
    logic [ELEMENT_WIDTH-1:0]            x_op;
    logic [LANES-1:0][ELEMENT_WIDTH-1:0] w_bus;
    logic [LANES-1:0][ELEMENT_WIDTH-1:0] z_bus;

    assign start  = (state == ST_IDLE || state == ST_DONE) && en;
    assign mac_en = (state == ST_WAIT) && w_element_ready;
    assign emit   = (state == ST_EMIT);
    // A weight may land in the same cycle the RAM word arrives, before x_reg holds it.
    assign x_op   = first_wait ? x_ram_data : x_reg;
    assign w_bus  = {w3_element, w2_element, w1_element, w0_element};

    always_ff @(posedge clock) begin
        if (clear) begin
            state               <= ST_IDLE;
            i                   <= '0;
            j                   <= '0;
            x_reg               <= '0;
            first_wait          <= 1'b0;
            x_ram_address       <= '0;
            x_ram_enable        <= 1'b0;
            w_element_requested <= 1'b0;
            z_ready             <= 1'b0;
            finished            <= 1'b0;
        end else begin
            x_ram_enable        <= 1'b0;
            w_element_requested <= 1'b0;
            z_ready             <= 1'b0;
            first_wait          <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (en) begin
                        state               <= ST_FETCH;
                        i                   <= '0;
                        j                   <= '0;
                        finished            <= 1'b0;
                        x_ram_address       <= '0;
                        x_ram_enable        <= 1'b1;
                        w_element_requested <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state      <= ST_WAIT;
                    first_wait <= 1'b1;
                end
                ST_WAIT: begin
                    if (first_wait)
                        x_reg <= x_ram_data;
                    if (w_element_ready) begin
                        if (i == I_LAST) begin
                            state <= ST_EMIT;
                        end else begin
                            state               <= ST_FETCH;
                            i                   <= i + X_ADDR_WIDTH'(1);
                            x_ram_address       <= i + X_ADDR_WIDTH'(1);
                            x_ram_enable        <= 1'b1;
                            w_element_requested <= 1'b1;
                        end
                    end else begin
                        first_wait <= 1'b0;
                    end
                end
                ST_EMIT: begin
                    i       <= '0;
                    z_ready <= 1'b1;
                    if (j == J_LAST) begin
                        state    <= ST_DONE;
                        finished <= 1'b1;
                    end else begin
                        state               <= ST_FETCH;
                        j                   <= j + 4'd1;
                        x_ram_address       <= '0;
                        x_ram_enable        <= 1'b1;
                        w_element_requested <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mac_lane u_lane (
            .clock  (clock),
            .clear  (clear),
            .start  (start),
            .mac_en (mac_en),
            .emit   (emit),
            .x      (x_op),
            .w      (w_bus[k]),
            .z      (z_bus[k])
        );
    end

    assign z0_element       = z_bus[0];
    assign z1_element       = z_bus[1];
    assign z2_element       = z_bus[2];
    assign z3_element       = z_bus[3];
    assign z0_element_ready = z_ready;
    assign z1_element_ready = z_ready;
    assign z2_element_ready = z_ready;
    assign z3_element_ready = z_ready;

endmodule

// File: tb/tb_first_stage.sv
// Randomized scoreboard bench for first_stage: weight/RAM responders, a neuron-level
// reference model filling an expected queue, and a monitor that checks each ready strobe.
module tb_first_stage;

    localparam int N  = 16;
    localparam int AW = 4;

    logic          clock = 0;
    logic          clear = 1;
    logic          en = 0;
    logic [AW-1:0] x_ram_address;
    logic          x_ram_enable;
    logic [15:0]   x_ram_data = 0;
    logic          w_element_requested;
    logic          w_element_ready = 0;
    logic [15:0]   w0_element = 0, w1_element = 0, w2_element = 0, w3_element = 0;
    logic [15:0]   z0_element, z1_element, z2_element, z3_element;
    logic          z0_element_ready, z1_element_ready, z2_element_ready, z3_element_ready;
    logic          finished;

    first_stage #(.INPUT_LENGTH(N), .X_ADDR_WIDTH(AW)) dut (
        .clock(clock), .clear(clear), .en(en),
        .x_ram_address(x_ram_address), .x_ram_enable(x_ram_enable), .x_ram_data(x_ram_data),
        .w_element_requested(w_element_requested), .w_element_ready(w_element_ready),
        .w0_element(w0_element), .w1_element(w1_element),
        .w2_element(w2_element), .w3_element(w3_element),
        .z0_element(z0_element), .z1_element(z1_element),
        .z2_element(z2_element), .z3_element(z3_element),
        .z0_element_ready(z0_element_ready), .z1_element_ready(z1_element_ready),
        .z2_element_ready(z2_element_ready), .z3_element_ready(z3_element_ready),
        .finished(finished)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int fails   = 0;

    logic signed [15:0] xm [N];
    logic signed [15:0] wm [64][N];
    logic [63:0]        exp_q [$];

    int dmin = 1, dmax = 1;
    bit stray = 0;
    int bcnt = 0, beats_done = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: neuron n = 16k+j, dot product scaled back to Q8.8, ReLU, clamp.
    function automatic logic [15:0] model_z(input int n);
        longint acc, r;
        acc = 0;
        for (int t = 0; t < N; t++) acc += longint'(xm[t]) * longint'(wm[n][t]);
        r = acc >>> 8;
        if (r > 32767) return 16'h7FFF;
        if (r < 0) return 16'h0000;
        return 16'(r);
    endfunction

    task automatic fill(input int mode);
        for (int t = 0; t < N; t++) begin
            case (mode)
                3, 4:    xm[t] = 16'sh7FFF;
                5:       xm[t] = 16'($signed($urandom_range(0, 2047)) - 1024);
                default: xm[t] = 16'sh0100;
            endcase
            for (int n = 0; n < 64; n++) begin
                case (mode)
                    1:       wm[n][t] = 16'((n / 16 + 1) * 16'h0080);
                    2:       wm[n][t] = (n < 16) ? 16'shFF00 : 16'sh0100;
                    3:       wm[n][t] = 16'sh7FFF;
                    4:       wm[n][t] = 16'sh8000;
                    5:       wm[n][t] = 16'($signed($urandom_range(0, 2047)) - 1024);
                    default: wm[n][t] = 16'sh0100;
                endcase
            end
        end
    endtask

    // RAM and weight responder; one outstanding request, delay dmin..dmax cycles.
    initial begin
        bit pending;
        int cnt, pj, pi;
        pending = 0; cnt = 0; pj = 0; pi = 0;
        forever begin
            @(negedge clock);
            w_element_ready = 0;
            if (clear) begin
                pending = 0;
            end else begin
                if (x_ram_enable) x_ram_data = xm[x_ram_address];
                if (pending) begin
                    cnt--;
                    if (cnt <= 0) begin
                        w_element_ready = 1;
                        w0_element = wm[pj][pi];
                        w1_element = wm[16 + pj][pi];
                        w2_element = wm[32 + pj][pi];
                        w3_element = wm[48 + pj][pi];
                        pending = 0;
                        beats_done++;
                    end
                end
                if (w_element_requested) begin
                    pj = bcnt / N;
                    pi = bcnt % N;
                    chk("x_addr", 64'(x_ram_address), 64'(pi));
                    bcnt++;
                    pending = 1;
                    cnt = $urandom_range(dmin, dmax);
                    if (stray && $urandom_range(0, 2) == 0) begin
                        w_element_ready = 1;
                        w0_element = 16'($urandom); w1_element = 16'($urandom);
                        w2_element = 16'($urandom); w3_element = 16'($urandom);
                    end
                end
            end
        end
    end

    // Monitor: every strobe must match the head of the expected queue.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clock);
            if (z0_element_ready | z1_element_ready | z2_element_ready | z3_element_ready) begin
                chk("ready_together", 64'({z3_element_ready, z2_element_ready, z1_element_ready, z0_element_ready}), 64'hF);
                if (exp_q.size() == 0) begin
                    vectors++; fails++;
                    $display("FAIL unexpected_pulse: got strobe z=%h_%h_%h_%h, expected none at %0t",
                             z3_element, z2_element, z1_element, z0_element, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("z0", 64'(z0_element), 64'(e[15:0]));
                    chk("z1", 64'(z1_element), 64'(e[31:16]));
                    chk("z2", 64'(z2_element), 64'(e[47:32]));
                    chk("z3", 64'(z3_element), 64'(e[63:48]));
                end
            end
        end
    end

    task automatic check_idle(input string nm);
        chk({nm, "_z"}, {z3_element, z2_element, z1_element, z0_element}, 64'h0);
        chk({nm, "_ctl"}, 64'({z0_element_ready, w_element_requested, x_ram_enable, finished}), 64'h0);
        chk({nm, "_addr"}, 64'(x_ram_address), 64'h0);
    endtask

    // abort_beats > 0: clear the run once that many beats have been delivered.
    task automatic run_seq(input bit check_lat, input bit en_busy, input int abort_beats);
        int cyc;
        int nexp;
        nexp = (abort_beats > 0) ? abort_beats / N : 16;
        for (int j = 0; j < nexp; j++)
            exp_q.push_back({model_z(48 + j), model_z(32 + j), model_z(16 + j), model_z(j)});
        bcnt = 0;
        beats_done = 0;
        @(negedge clock);
        en = 1;
        @(negedge clock);
        en = 0;
        cyc = 1;
        if (abort_beats > 0) begin
            while (beats_done < abort_beats && cyc < 20000) begin
                @(negedge clock);
                cyc++;
            end
            chk("abort_reached", 64'(beats_done >= abort_beats), 64'h1);
            clear = 1;
            @(negedge clock);
            check_idle("abort_reset");
            @(negedge clock);
            clear = 0;
            repeat (80) @(negedge clock);
            chk("abort_drained", 64'(exp_q.size()), 64'h0);
            chk("abort_idle", 64'({x_ram_enable, w_element_requested, finished}), 64'h0);
        end else begin
            while (!finished && cyc < 20000) begin
                @(negedge clock);
                cyc++;
                if (en_busy) en = (cyc == 100 || cyc == 301);
            end
            en = 0;
            chk("finished", 64'(finished), 64'h1);
            if (check_lat) chk("latency", 64'(cyc - 1), 64'd528);
            chk("queue_empty", 64'(exp_q.size()), 64'h0);
            repeat (3) @(negedge clock);
            chk("finished_held", 64'(finished), 64'h1);
        end
        exp_q.delete();
    endtask

    initial begin
        fill(0);
        repeat (2) @(negedge clock);
        check_idle("reset");
        clear = 0;
        @(negedge clock);

        dmin = 1; dmax = 1; stray = 0;
        fill(0); run_seq(1, 0, 0);
        fill(1); run_seq(1, 0, 0);
        fill(2); run_seq(1, 0, 0);
        fill(3); run_seq(1, 0, 0);
        fill(4); run_seq(1, 0, 0);
        fill(5); run_seq(1, 0, 0);
        dmin = 1; dmax = 5; stray = 1;
        run_seq(0, 0, 0);

        dmin = 1; dmax = 3; stray = 0;
        fill(0); run_seq(0, 0, 3 * N + 5);
        fill(5); run_seq(0, 1, 0);
        dmin = 1; dmax = 1;
        fill(1); run_seq(1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/first_stage.md
# first_stage

Hidden-layer engine ahead of the second stage. Holds an input vector in an external input RAM and computes 64 hidden activations as four parallel lanes of 16 neurons. Each lane multiplies the input by a streamed weight row, rescales and saturates to Q8.8, and applies ReLU. The four results are presented on `z0..z3_element` with ready strobes, in the format the second stage's z caches store directly.

## Interface
- `INPUT_LENGTH`, default 16: number of input elements per neuron (dot-product length), 2..256.
- `X_ADDR_WIDTH`, default 4: input RAM address width; must satisfy 2^X_ADDR_WIDTH ≥ INPUT_LENGTH.
- `clock` input 1: the only clock; all state updates on its rising edge.
- `clear` input 1: synchronous, active-high reset.
- `en` input 1: start pulse, sampled only in IDLE or DONE.
- `x_ram_address` output X_ADDR_WIDTH: input RAM read address.
- `x_ram_enable` output 1: input RAM read enable; data valid 1 cycle later.
- `x_ram_data` input 16: input element, signed Q8.8.
- `w_element_requested` output 1: one-cycle pulse requesting the next weight beat.
- `w_element_ready` input 1: one-cycle pulse; `w0..w3_element` are valid this cycle.
- `w0_element`..`w3_element` input 16 each: per-lane weights, signed Q8.8.
- `z0_element`..`z3_element` output 16 each: lane results, Q8.8, range 0..0x7FFF.
- `z0_element_ready`..`z3_element_ready` output 1 each: one-cycle pulses, always asserted together.
- `finished` output 1: level, high in DONE.

## Operation
- States: IDLE, FETCH, WAIT, EMIT, DONE.
- Counters:
  - `i` (input index, 0..INPUT_LENGTH-1)
  - `j` (neuron index, 0..15)
  - lane k in neuron step j computes neuron 16k+j.
- IDLE/DONE with `en`=1: go to FETCH; i=0, j=0, accumulators cleared, `finished` cleared.
- FETCH (1 cycle):
  - `x_ram_enable`=1, `x_ram_address`=i, `w_element_requested`=1.
  - Next state WAIT.
- WAIT:
  - First WAIT cycle: capture `x_ram_data` into `x_reg`.
  - On `w_element_ready`: acc_k += x_reg × w_k (signed 16×16 → 32-bit, summed into a 40-bit accumulator).
  - If i = INPUT_LENGTH-1 go to EMIT; otherwise i++ and go to FETCH.
- EMIT (1 cycle):
  - Per lane: r = acc_k >>> 8 (arithmetic shift); r > 32767 → 0x7FFF; r < 0 → 0.
  - Register r onto `zk_element`; pulse all `zk_element_ready`.
  - Clear accumulators, i=0.
  - If j = 15 go to DONE; otherwise j++ and go to FETCH.
- DONE: `finished`=1 and held until `clear` or a new `en`.
- `en` in FETCH, WAIT or EMIT is ignored.
- `w_element_ready` outside WAIT is ignored; it must not arrive in the FETCH cycle itself.
- At most one weight request is outstanding at any time.

## Timing
- Reset (`clear`=1), effective the next edge:
  - State IDLE; all counters and accumulators 0.
  - All `zk_element` = 0; all ready pulses, `w_element_requested`, `x_ram_enable` and `finished` = 0.
  - `x_ram_address` = 0.
- `clear` mid-operation aborts immediately: no further ready pulses, and any partial neuron is discarded.
- `clear` takes priority over `en` in the same cycle.
- Minimum 2 cycles per weight beat (FETCH + 1 WAIT). `w_element_ready` may come at the earliest 1 cycle after the request pulse, with unbounded delay.
- Each neuron step costs ≥ 2·INPUT_LENGTH + 1 cycles. With zero-delay weights, `finished` rises 16·(2·INPUT_LENGTH+1) cycles after the `en` edge.
- `zk_element` is valid in the same cycle as its ready pulse and holds its value until the next EMIT or `clear`.
- Ready pulses are separated by ≥ 2·INPUT_LENGTH cycles. This gives the downstream z caches time to write.

## Structure
- Shared package/constants file, also used by second_stage:
  - `Q_FRAC_BITS`=8, `ELEMENT_WIDTH`=16, `ACC_WIDTH`=40, `LANES`=4, `NEURONS_PER_LANE`=16.
  - Q8.8 max/min constants.
  - FSM state encoding.
- One sub-module, `mac_lane`, instantiated 4×. It holds:
  - the accumulator,
  - multiply-accumulate enable,
  - clear,
  - shift/saturate/ReLU output register.
- The top level holds the FSM, the i/j counters, `x_reg` and the handshake.

## Test plan
- x all 0x0100, all w 0x0100, INPUT_LENGTH=16, zero-delay ready: 16 EMITs. Every z = 0x1000 on every lane; then `finished`=1 with latency 528 cycles.
- Lane distinction: w_k = (k+1)·0x0080, x all 0x0100 → z0..z3 = 0x0800, 0x1000, 0x1800, 0x2000 on every pulse.
- ReLU: x = 0x0100, w0 = 0xFF00 (−1.0), others 0x0100 → z0 = 0x0000, z1..z3 = 0x1000.
- Saturation: x = 0x7FFF, w = 0x7FFF → all z = 0x7FFF; x = 0x7FFF, w = 0x8000 → all z = 0.
- Random `w_element_ready` delay 1..5 cycles, plus a stray ready pulse in FETCH → results identical to the zero-delay run; the stray pulse has no effect.
- `clear` after 5 beats of neuron 3 → outputs 0, no ready pulse, IDLE. Fresh `en` → a correct full 16-neuron sequence. `en` while busy → ignored.
